// File: rtl/mdu_ctrl.sv
// Multiply/divide unit sequencer: latency counter, HI/LO ownership, stall request.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops (7..10).
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  input  logic        use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam int unsigned CW = 4;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [3:0]     op_q;
  logic [31:0]    a_q;
  logic [31:0]    b_q;

  logic           mul_op;
  logic           div_op;
  logic           long_op;
  logic [63:0]    prod_s;
  logic [63:0]    prod_u;
  logic           div_s;
  logic           a_neg;
  logic           b_neg;
  logic [31:0]    mag_a;
  logic [31:0]    mag_b;
  logic [31:0]    quo_u;
  logic [31:0]    rem_u;
  logic [31:0]    quo;
  logic [31:0]    rem;
  logic [63:0]    res;
  logic           div_zero;

  // Classify the incoming E-stage op; accumulate ops only count when enabled.
  always_comb begin
    mul_op = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    mul_op = mul_op || (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    div_op  = (op == OP_DIV) || (op == OP_DIVU);
    long_op = mul_op || div_op;
  end

  // Low 64 bits of a sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly.
  always_comb begin
    div_s = (op_q == OP_DIV);
    a_neg = div_s & a_q[31];
    b_neg = div_s & b_q[31];
    mag_a = a_neg ? (32'd0 - a_q) : a_q;
    mag_b = b_neg ? (32'd0 - b_q) : b_q;
    quo_u = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
    rem_u = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
    quo   = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
    rem   = a_neg ? (32'd0 - rem_u) : rem_u;
    div_zero = ((op_q == OP_DIV) || (op_q == OP_DIVU)) && (b_q == 32'd0);
  end

  // Value written to {hi,lo} on the completion edge.
  always_comb begin
    res = {hi, lo};
    case (op_q)
      OP_MULT:          res = prod_s;
      OP_MULTU:         res = prod_u;
      OP_DIV, OP_DIVU:  res = {rem, quo};
`ifdef MDU_MADD_EN
      OP_MADD:          res = {hi, lo} + prod_s;
      OP_MADDU:         res = {hi, lo} + prod_u;
      OP_MSUB:          res = {hi, lo} - prod_s;
      OP_MSUBU:         res = {hi, lo} - prod_u;
`endif
      default:          res = {hi, lo};
    endcase
  end

  // Sequencer and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (long_op) begin
              op_q  <= op;
              a_q   <= a;
              b_q   <= b;
              cnt   <= mul_op ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
              state <= RUN;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          if (cnt == '0) begin
            if (!div_zero) begin
              hi <= res[63:32];
              lo <= res[31:0];
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign stall   = reset & use_d & (busy | (start & long_op));
  assign mdu_out = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, multi-cycle corner
// sequences and randomized ops against an arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_sel;
  logic        use_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_sel(rd_sel), .use_d(use_d), .busy(busy), .stall(stall),
    .hi(hi), .lo(lo), .mdu_out(mdu_out)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } model_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: architectural effect of one op on {hi,lo} plus its busy length.
  function automatic model_t model(input logic [3:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input logic [31:0] h,
                                   input logic [31:0] l);
    model_t m;
    longint sx, sy, q, r, p;
    longint unsigned ux, uy, up, acc;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    acc = {h, l};
    m.hi = h; m.lo = l; m.cyc = 0;
    case (o)
      4'd1: begin p = sx * sy; m.hi = p[63:32]; m.lo = p[31:0]; m.cyc = MC; end
      4'd2: begin up = ux * uy; m.hi = up[63:32]; m.lo = up[31:0]; m.cyc = MC; end
      4'd3: begin
        m.cyc = DC;
        if (y != 0) begin q = sx / sy; r = sx % sy; m.lo = q[31:0]; m.hi = r[31:0]; end
      end
      4'd4: begin
        m.cyc = DC;
        if (y != 0) begin up = ux / uy; acc = ux % uy; m.lo = up[31:0]; m.hi = acc[31:0]; end
      end
      4'd5: m.hi = x;
      4'd6: m.lo = x;
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: begin
        p  = sx * sy;
        up = ux * uy;
        if (o == 4'd7)      acc = acc + longint'(p);
        else if (o == 4'd8) acc = acc + up;
        else if (o == 4'd9) acc = acc - longint'(p);
        else                acc = acc - up;
        m.hi = acc[63:32]; m.lo = acc[31:0]; m.cyc = MC;
      end
`endif
      default: ;
    endcase
    return m;
  endfunction

  // Issue one op and count busy cycles; operands scrambled while busy.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cyc);
    start = 1'b1; op = o; a = x; b = y;
    tick;
    start = 1'b0; op = 4'd0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      a = $urandom; b = $urandom;
      tick;
    end
  endtask

  vec_t   vecs[$];
  model_t m;
  int     cyc;
  logic [31:0] m_hi, m_lo;

  initial begin
    reset = 1'b0; start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
    rd_sel = 1'b0; use_d = 1'b1;

    // Reset state, stall held low in reset despite use_d & start.
    #3;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    start = 1'b0; use_d = 1'b0; op = 4'd0;
    tick; tick;
    reset = 1'b1;
    tick;
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_hi", hi, 32'd0);

    vecs.push_back('{4'd1,  32'd3,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, MC});
    vecs.push_back('{4'd2,  32'd3,        32'hFFFFFFFE, 32'h00000002, 32'hFFFFFFFA, MC});
    vecs.push_back('{4'd4,  32'd7,        32'd2,        32'd1,        32'd3,        DC});
    vecs.push_back('{4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC});
    vecs.push_back('{4'd5,  32'h11,       32'd0,        32'h11,       32'hFFFFFFFD, 0});
    vecs.push_back('{4'd6,  32'h22,       32'd0,        32'h11,       32'h22,       0});
    vecs.push_back('{4'd3,  32'd1234,     32'd0,        32'h11,       32'h22,       DC});
    vecs.push_back('{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC});
    vecs.push_back('{4'd5,  32'd0,        32'd0,        32'd0,        32'h80000000, 0});
    vecs.push_back('{4'd6,  32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFF, 0});
`ifdef MDU_MADD_EN
    vecs.push_back('{4'd8,  32'd1,        32'd1,        32'd1,        32'd0,        MC});
`else
    vecs.push_back('{4'd8,  32'd1,        32'd1,        32'd0,        32'hFFFFFFFF, 0});
`endif
    vecs.push_back('{4'd0,  32'd9,        32'd9,        vecs[10].exp_hi, vecs[10].exp_lo, 0});
    vecs.push_back('{4'd13, 32'd9,        32'd9,        vecs[10].exp_hi, vecs[10].exp_lo, 0});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      rd_sel = 1'b1; #1;
      chk($sformatf("vec%0d_mdu_out_hi", i), mdu_out, vecs[i].exp_hi);
      rd_sel = 1'b0;
    end

    // Stall during start cycle and every busy cycle of a MULT.
    use_d = 1'b1; start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
    #1;
    chk("stall_start", {31'd0, stall}, 32'd1);
    tick;
    start = 1'b0; op = 4'd0;
    for (int i = 0; i < MC; i++) begin
      chk($sformatf("stall_busy%0d", i), {30'd0, busy, stall}, 32'd3);
      tick;
    end
    chk("stall_idle", {30'd0, busy, stall}, 32'd0);
    chk("stall_mult_lo", lo, 32'd12);
    start = 1'b1; op = 4'd5; a = 32'd5;
    #1;
    chk("stall_mthi", {31'd0, stall}, 32'd0);
    tick;
    start = 1'b0; op = 4'd0; use_d = 1'b0;
    chk("mthi_hi", hi, 32'd5);

    // use_d low while busy: no stall.
    start = 1'b1; op = 4'd4; a = 32'd100; b = 32'd7;
    tick;
    start = 1'b0; op = 4'd0;
    chk("nouse_stall", {30'd0, busy, stall}, 32'd2);
    cyc = 1;
    while (busy === 1'b1 && cyc < 40) begin cyc++; tick; end
    chk("divu_cycles", 32'(cyc), 32'(DC + 1));
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // start while busy is ignored: no restart, no operand reload.
    start = 1'b1; op = 4'd1; a = 32'd7; b = 32'd6;
    tick;
    op = 4'd3; a = 32'd100; b = 32'd1;
    tick;
    op = 4'd5; a = 32'hDEAD;
    tick;
    start = 1'b0; op = 4'd0;
    cyc = 3;
    while (busy === 1'b1 && cyc < 40) begin cyc++; tick; end
    chk("busy_start_cycles", 32'(cyc), 32'(MC + 1));
    chk("busy_start_hi", hi, 32'd0);
    chk("busy_start_lo", lo, 32'd42);

    // Async reset mid-RUN aborts and clears HI/LO.
    start = 1'b1; op = 4'd5; a = 32'h55;
    tick;
    op = 4'd1; a = 32'd9; b = 32'd9;
    tick;
    start = 1'b0; op = 4'd0;
    tick;
    #2 reset = 1'b0;
    #1;
    chk("midrun_busy", {31'd0, busy}, 32'd0);
    chk("midrun_hi", hi, 32'd0);
    chk("midrun_lo", lo, 32'd0);
    tick;
    reset = 1'b1;
    tick;

    // Randomized ops against the reference model.
    m_hi = 32'd0; m_lo = 32'd0;
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      m = model(ro, ra, rb, m_hi, m_lo);
      run_op(ro, ra, rb, cyc);
      m_hi = m.hi; m_lo = m.lo;
      chk($sformatf("rnd%0d_op%0d_cycles", i, ro), 32'(cyc), 32'(m.cyc));
      chk($sformatf("rnd%0d_op%0d_hi", i, ro), hi, m.hi);
      chk($sformatf("rnd%0d_op%0d_lo", i, ro), lo, m.lo);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
